// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with byte enables, store-lane replication and misalignment detection.
// Optional hold/bubble performance counters are enabled by defining EX_MEM_STAGE_PERF_EN.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_stall,
  input  logic                ex_flush,
  input  logic                me_ready,
  output logic                ex_ready,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                ex_mem_to_reg,
  input  logic                ex_reg_write,
  input  logic [1:0]          ex_mem_size,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [DATA_W-1:0]   ex_reg2_fwd,
  input  logic [REG_W-1:0]    ex_rt_rd,
  output logic                me_valid,
  output logic                me_mem_read,
  output logic                me_mem_write,
  output logic                me_mem_to_reg,
  output logic                me_reg_write,
  output logic [DATA_W-1:0]   me_alu_result,
  output logic [DATA_W-1:0]   me_data2_reg,
  output logic [DATA_W/8-1:0] me_byte_en,
  output logic                me_addr_err,
  output logic [REG_W-1:0]    me_rt_rd
`ifdef EX_MEM_STAGE_PERF_EN
  ,
  output logic [31:0]         me_hold_cnt,
  output logic [31:0]         me_bubble_cnt
`endif
);
  localparam int BE = DATA_W / 8;
  localparam int OW = $clog2(BE);
  logic hold, bubble, misal;
  logic [OW-1:0] off;
  logic [1:0] size;
  logic [BE-1:0] be_raw;
  logic [DATA_W-1:0] rep;
  logic valid_q, valid_d, rd_q, rd_d, wr_q, wr_d, m2r_q, m2r_d, rw_q, rw_d, err_q, err_d;
  logic [DATA_W-1:0] alu_q, alu_d, data_q, data_d;
  logic [BE-1:0] be_q, be_d;
  logic [REG_W-1:0] rt_q, rt_d;
  assign hold = valid_q & ~me_ready & ~ex_flush;
  assign ex_ready = ~hold;
  // flush and stall both leave a non-instruction slot, so they share one path
  assign bubble = ex_flush | ex_stall;
  always_comb begin
    off = ex_alu_result[OW-1:0];
    size = (DATA_W == 32 && ex_mem_size == 2'b11) ? 2'b10 : ex_mem_size;
    be_raw = size == 2'd0 ? BE'(1) << off :
             size == 2'd1 ? BE'(3) << off :
             size == 2'd2 ? BE'(15) << off : '1;
    misal = (ex_mem_read | ex_mem_write) &
            (size == 2'd1 ? off[0] : size == 2'd2 ? |off[1:0] : size == 2'd3 ? |off : 1'b0);
    rep = size == 2'd0 ? {BE{ex_reg2_fwd[7:0]}} :
          size == 2'd1 ? {(BE/2){ex_reg2_fwd[15:0]}} :
          size == 2'd2 ? {(DATA_W/32){ex_reg2_fwd[31:0]}} : ex_reg2_fwd;
    valid_d = hold ? valid_q : ~bubble;
    rd_d = hold ? rd_q : ~bubble & ~misal & ex_mem_read;
    wr_d = hold ? wr_q : ~bubble & ~misal & ex_mem_write;
    rw_d = hold ? rw_q : ~bubble & ~misal & ex_reg_write;
    err_d = hold ? err_q : ~bubble & misal;
    be_d = hold ? be_q : (bubble | misal) ? '0 : be_raw;
    m2r_d = hold ? m2r_q : ex_mem_to_reg;
    alu_d = hold ? alu_q : ex_alu_result;
    data_d = hold ? data_q : rep;
    rt_d = hold ? rt_q : ex_rt_rd;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      m2r_q <= 1'b0;
      rw_q <= 1'b0;
      err_q <= 1'b0;
      alu_q <= '0;
      data_q <= '0;
      be_q <= '0;
      rt_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      m2r_q <= m2r_d;
      rw_q <= rw_d;
      err_q <= err_d;
      alu_q <= alu_d;
      data_q <= data_d;
      be_q <= be_d;
      rt_q <= rt_d;
    end
  end
  assign me_valid = valid_q;
  assign me_mem_read = rd_q;
  assign me_mem_write = wr_q;
  assign me_mem_to_reg = m2r_q;
  assign me_reg_write = rw_q;
  assign me_alu_result = alu_q;
  assign me_data2_reg = data_q;
  assign me_byte_en = be_q;
  assign me_addr_err = err_q;
  assign me_rt_rd = rt_q;
`ifdef EX_MEM_STAGE_PERF_EN
  logic [31:0] hold_cnt_q, hold_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    hold_cnt_d = hold_cnt_q + {31'd0, hold && hold_cnt_q != '1};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ex_stall && !ex_flush && !hold && bubble_cnt_q != '1};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign me_hold_cnt = hold_cnt_q;
  assign me_bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: random and directed checks of ex_mem_stage (DATA_W=32) against a behavioural model.
module tb_ex_mem_stage;
  logic clock = 0, reset = 1;
  logic ex_stall = 0, ex_flush = 0, me_ready = 1, ex_ready;
  logic ex_mem_read = 0, ex_mem_write = 0, ex_mem_to_reg = 0, ex_reg_write = 0;
  logic [1:0] ex_mem_size = 0;
  logic [31:0] ex_alu_result = 0, ex_reg2_fwd = 0;
  logic [4:0] ex_rt_rd = 0;
  logic me_valid, me_mem_read, me_mem_write, me_mem_to_reg, me_reg_write, me_addr_err;
  logic [31:0] me_alu_result, me_data2_reg;
  logic [3:0] me_byte_en;
  logic [4:0] me_rt_rd;
`ifdef EX_MEM_STAGE_PERF_EN
  logic [31:0] me_hold_cnt, me_bubble_cnt;
`endif
  int errors = 0, checks = 0;
  bit started = 0;
  logic m_valid = 0, m_rd = 0, m_wr = 0, m_m2r = 0, m_rw = 0, m_err = 0;
  logic [31:0] m_alu = 0, m_data = 0;
  logic [3:0] m_be = 0;
  logic [4:0] m_rt = 0;
  longint m_hold = 0, m_bub = 0;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clock(clock), .reset(reset), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .me_ready(me_ready), .ex_ready(ex_ready), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_size(ex_mem_size), .ex_alu_result(ex_alu_result), .ex_reg2_fwd(ex_reg2_fwd),
    .ex_rt_rd(ex_rt_rd), .me_valid(me_valid), .me_mem_read(me_mem_read),
    .me_mem_write(me_mem_write), .me_mem_to_reg(me_mem_to_reg), .me_reg_write(me_reg_write),
    .me_alu_result(me_alu_result), .me_data2_reg(me_data2_reg), .me_byte_en(me_byte_en),
    .me_addr_err(me_addr_err), .me_rt_rd(me_rt_rd)
`ifdef EX_MEM_STAGE_PERF_EN
    , .me_hold_cnt(me_hold_cnt), .me_bubble_cnt(me_bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << ((sz == 2'd3) ? 2 : int'(sz));
  endfunction

  function automatic logic [31:0] rep32(input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    longint chunk = longint'(d) & ((64'd1 << (8 * n)) - 1);
    longint r = 0;
    for (int i = 0; i < 4; i += n) r |= chunk << (8 * i);
    return r[31:0];
  endfunction

  // Behavioural model: expected registered state after each rising edge
  always @(posedge clock) begin
    int n, off;
    bit mis;
    if (reset) begin
      {m_valid, m_rd, m_wr, m_m2r, m_rw, m_err} = '0;
      m_alu = 0; m_data = 0; m_be = 0; m_rt = 0; m_hold = 0; m_bub = 0;
      started = 1;
    end else if (ex_flush || (!(m_valid && !me_ready) && ex_stall)) begin
      if (!ex_flush) m_bub = (m_bub == 64'hFFFFFFFF) ? m_bub : m_bub + 1;
      {m_valid, m_rd, m_wr, m_rw, m_err} = '0;
      m_be = 0;
      m_m2r = ex_mem_to_reg; m_alu = ex_alu_result; m_rt = ex_rt_rd;
      m_data = rep32(ex_mem_size, ex_reg2_fwd);
    end else if (m_valid && !me_ready) begin
      m_hold = (m_hold == 64'hFFFFFFFF) ? m_hold : m_hold + 1;
    end else begin
      n = nbytes(ex_mem_size);
      off = int'(ex_alu_result % 4);
      mis = (ex_mem_read || ex_mem_write) && (off % n != 0);
      m_valid = 1;
      m_rd = ex_mem_read && !mis;
      m_wr = ex_mem_write && !mis;
      m_rw = ex_reg_write && !mis;
      m_err = mis;
      m_be = mis ? 4'h0 : 4'(((1 << n) - 1) << off);
      m_m2r = ex_mem_to_reg; m_alu = ex_alu_result; m_rt = ex_rt_rd;
      m_data = rep32(ex_mem_size, ex_reg2_fwd);
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("ex_ready", ex_ready, !(m_valid && !me_ready && !ex_flush));
      chk("me_valid", me_valid, m_valid);
      chk("me_mem_read", me_mem_read, m_rd);
      chk("me_mem_write", me_mem_write, m_wr);
      chk("me_mem_to_reg", me_mem_to_reg, m_m2r);
      chk("me_reg_write", me_reg_write, m_rw);
      chk("me_alu_result", me_alu_result, m_alu);
      chk("me_data2_reg", me_data2_reg, m_data);
      chk("me_byte_en", me_byte_en, m_be);
      chk("me_addr_err", me_addr_err, m_err);
      chk("me_rt_rd", me_rt_rd, m_rt);
`ifdef EX_MEM_STAGE_PERF_EN
      chk("me_hold_cnt", me_hold_cnt, m_hold);
      chk("me_bubble_cnt", me_bubble_cnt, m_bub);
`endif
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ex(input bit rd, input bit wr, input bit rw, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw; ex_mem_to_reg = rd;
    ex_mem_size = sz; ex_alu_result = a; ex_reg2_fwd = d; ex_rt_rd = 5'($urandom);
  endtask

  initial begin
    tick; tick;
    reset = 0;
    chk("rst_valid", me_valid, 0);
    chk("rst_byte_en", me_byte_en, 0);
    chk("rst_ex_ready", ex_ready, 1);
    set_ex(0, 1, 0, 2'b10, 32'h1000, 32'hAABBCCDD);
    tick;
    chk("word_valid", me_valid, 1);
    chk("word_be", me_byte_en, 4'hF);
    chk("word_data", me_data2_reg, 32'hAABBCCDD);
    set_ex(0, 1, 0, 2'b00, 32'h1003, 32'h000000EE);
    tick;
    chk("byte_be", me_byte_en, 4'b1000);
    chk("byte_data", me_data2_reg, 32'hEEEEEEEE);
    chk("byte_err", me_addr_err, 0);
    set_ex(1, 0, 1, 2'b01, 32'h1001, 32'h0);
    tick;
    chk("half_err", me_addr_err, 1);
    chk("half_rd", me_mem_read, 0);
    chk("half_rw", me_reg_write, 0);
    chk("half_be", me_byte_en, 0);
    set_ex(0, 1, 0, 2'b10, 32'h2000, 32'h12345678);
    tick;
    me_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
      ex_stall = 1'($urandom);
      #1 chk("hold_ex_ready", ex_ready, 0);
      tick;
      chk("hold_valid", me_valid, 1);
      chk("hold_alu", me_alu_result, 32'h2000);
      chk("hold_data", me_data2_reg, 32'h12345678);
      chk("hold_be", me_byte_en, 4'hF);
    end
`ifdef EX_MEM_STAGE_PERF_EN
    chk("hold_cnt3", me_hold_cnt, 3);
`endif
    ex_stall = 0;
    ex_flush = 1;
    set_ex(0, 1, 0, 2'b10, 32'h3000, 32'h55);
    #1 chk("flush_ex_ready_now", ex_ready, 1);
    tick;
    ex_flush = 0;
    chk("flush_valid", me_valid, 0);
    chk("flush_wr", me_mem_write, 0);
    chk("flush_ex_ready", ex_ready, 1);
    ex_stall = 1;
    set_ex(0, 0, 1, 2'b10, 32'h4000, 32'h66);
    tick;
    ex_stall = 0;
    chk("stall_rw", me_reg_write, 0);
    chk("stall_valid", me_valid, 0);
`ifdef EX_MEM_STAGE_PERF_EN
    chk("bubble_cnt1", me_bubble_cnt, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      set_ex(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
      me_ready = $urandom_range(0, 9) < 7;
      ex_flush = $urandom_range(0, 19) == 0;
      ex_stall = $urandom_range(0, 6) == 0;
      reset = $urandom_range(0, 59) == 0;
      tick;
    end
    reset = 0;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
